// File: rtl/psg_envelope_generator.sv
// ADSR envelope generator for one PSG voice: gate-driven level FSM plus sample scaling.
// Optional build macro PSG_ENV_EXPDECAY_EN selects piecewise-exponential decay/release.
module psg_envelope_generator #(
    parameter int unsigned PRESCALE = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        test,
    input  logic        gate,
    input  logic [7:0]  atk,
    input  logic [7:0]  dec,
    input  logic [7:0]  sus,
    input  logic [7:0]  rel,
    input  logic [15:0] tone_i,
    output logic [7:0]  env,
    output logic [2:0]  state,
    output logic [15:0] o
);

`ifdef PSG_ENV_EXPDECAY_EN
    localparam int unsigned RCW = 11;
`else
    localparam int unsigned RCW = 8;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t         st, st_n;
    logic [7:0]     env_r, env_n;
    logic [RCW-1:0] rc, rc_n;
    logic [RCW-1:0] thr;
    logic [15:0]    pc;
    logic           gate_d;
    logic           tick;
    logic           step;
    logic           rise;
    logic [7:0]     rate;
    logic [23:0]    prod;

    assign tick  = (pc == 16'(PRESCALE - 1));
    assign rise  = gate & ~gate_d;
    assign step  = tick && (rc == thr);
    assign prod  = tone_i * env_r;
    assign env   = env_r;
    assign state = st;

    always_comb begin
        rate = '0;
        case (st)
            ATTACK:  rate = atk;
            DECAY:   rate = dec;
            RELEASE: rate = rel;
            default: rate = '0;
        endcase
    end

`ifdef PSG_ENV_EXPDECAY_EN
    logic [1:0]  k;
    logic [11:0] span;

    always_comb begin
        if (env_r[7])      k = 2'd0;
        else if (env_r[6]) k = 2'd1;
        else if (env_r[5]) k = 2'd2;
        else               k = 2'd3;
        // (rate+1)<<k needs 12 bits; the minus-one brings it back into 11
        span = (12'(rate) + 12'd1) << k;
        if (st == ATTACK) thr = RCW'(rate);
        else              thr = RCW'(span - 12'd1);
    end
`else
    always_comb begin
        thr = rate;
    end
`endif

    always_comb begin
        st_n  = st;
        env_n = env_r;
        rc_n  = rc;
        if (rise) begin
            st_n = ATTACK;
            rc_n = '0;
        end else if (!gate && (st == ATTACK || st == DECAY || st == SUSTAIN)) begin
            st_n = RELEASE;
            rc_n = '0;
        end else begin
            case (st)
                ATTACK: begin
                    if (tick) begin
                        if (step) begin
                            rc_n = '0;
                            if (env_r != 8'hFF) env_n = env_r + 8'd1;
                            if (env_n == 8'hFF) st_n = DECAY;
                        end else begin
                            rc_n = rc + 1'b1;
                        end
                    end
                end
                DECAY: begin
                    if (env_r <= sus) begin
                        st_n = SUSTAIN;
                        rc_n = '0;
                    end else if (tick) begin
                        if (step) begin
                            rc_n  = '0;
                            env_n = env_r - 8'd1;
                        end else begin
                            rc_n = rc + 1'b1;
                        end
                    end
                end
                SUSTAIN: begin
                    env_n = sus;
                    rc_n  = '0;
                end
                RELEASE: begin
                    if (env_r == 8'd0) begin
                        st_n = IDLE;
                        rc_n = '0;
                    end else if (tick) begin
                        if (step) begin
                            rc_n  = '0;
                            env_n = env_r - 8'd1;
                        end else begin
                            rc_n = rc + 1'b1;
                        end
                    end
                end
                default: begin
                    env_n = '0;
                    rc_n  = '0;
                end
            endcase
        end
    end

    // test keeps sampling gate so a held gate cannot retrigger once test drops
    always_ff @(posedge clk) begin
        if (rst || test) begin
            st     <= IDLE;
            env_r  <= '0;
            rc     <= '0;
            pc     <= '0;
            o      <= '0;
            gate_d <= rst ? 1'b0 : gate;
        end else begin
            st     <= st_n;
            env_r  <= env_n;
            rc     <= rc_n;
            pc     <= tick ? 16'd0 : pc + 16'd1;
            o      <= prod[23:8];
            gate_d <= gate;
        end
    end

endmodule
